// File: rtl/megabytebeat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : megabytebeat_pkg                                       |
// | Description : Shared PCM sample types and constants for the          |
// |               bytebeat stream path.                                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package megabytebeat_pkg;

  localparam int              PCM_W    = 8;
  localparam logic [PCM_W-1:0] PCM_MID = 8'h80;
  localparam int              PWM_BITS = 8;

  typedef logic [PCM_W-1:0] pcm_t;

endpackage : megabytebeat_pkg
`default_nettype wire

// File: rtl/pcm_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pcm_fifo                                               |
// | Description : Small synchronous FIFO of PCM samples. Pointers carry  |
// |               one extra bit so full and empty are distinguishable.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pcm_fifo
  import megabytebeat_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  pcm_t                     data,
  output pcm_t                     head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int c_aw = $clog2(DEPTH);

  pcm_t            r_mem [DEPTH];
  logic [c_aw:0]   r_wptr;
  logic [c_aw:0]   r_rptr;
  logic            w_do_push;
  logic            w_do_pop;

  // A full FIFO never overwrites and an empty one never advances.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage and pointers; the MSB of each pointer is the wrap marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[c_aw-1:0]] <= data;
        r_wptr                  <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  assign head  = r_mem[r_rptr[c_aw-1:0]];
  assign level = r_wptr - r_rptr;
  assign full  = (level == (c_aw + 1)'(DEPTH));
  assign empty = (r_wptr == r_rptr);

endmodule : pcm_fifo
`default_nettype wire

// File: rtl/pcm_stream_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pcm_stream_sink                                        |
// | Description : Back-pressuring consumer of a bytebeat PCM stream.     |
// |               Buffers samples, releases one per sample tick and      |
// |               renders the current sample as 8-bit PWM audio.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pcm_stream_sink
  import megabytebeat_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RATE_DIV = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PCM_W-1:0]         pcm_in,
  input  logic                     pcm_in_vld,
  output logic                     pcm_in_rdy,
  input  logic                     clear_underrun,
  output logic                     pwm,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun
);

  localparam int c_cnt_w = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_tick_val = c_cnt_w'(RATE_DIV - 1);

  logic                 r_run;
  logic [c_cnt_w-1:0]   r_rate_cnt;
  pcm_t                 r_pending;
  pcm_t                 r_duty;
  logic [PWM_BITS-1:0]  r_pwm_cnt;
  logic                 r_pwm;
  logic                 r_underrun;

  logic                 w_tick;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  pcm_t                 w_head;

  // Ready depends only on registered state, never on the producer's valid.
  assign w_tick     = (r_rate_cnt == c_tick_val);
  assign pcm_in_rdy = r_run && !w_full;
  assign w_push     = pcm_in_vld && pcm_in_rdy;
  assign w_pop      = w_tick && !w_empty;

  pcm_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .data  (pcm_in),
    .head  (w_head),
    .level (level),
    .full  (w_full),
    .empty (w_empty)
  );

  // Run flop delays acceptance so the reset-release edge never transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // Sample-rate divider; the terminal count cycle is the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_rate_cnt <= '0;
    else if (w_tick) r_rate_cnt <= '0;
    else             r_rate_cnt <= r_rate_cnt + 1'b1;
  end

  // Pending sample takes the FIFO head on a tick; an empty tick holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_pending <= PCM_MID;
    else if (w_pop) r_pending <= w_head;
  end

  // Sticky underrun: an empty tick sets it and outranks a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_underrun <= 1'b0;
    else if (w_tick && w_empty)  r_underrun <= 1'b1;
    else if (clear_underrun)     r_underrun <= 1'b0;
  end

  // PWM: duty reloads only as the counter wraps so a period is never split.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
      r_duty    <= PCM_MID;
      r_pwm     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == '1) begin
        r_duty <= r_pending;
      end
      r_pwm <= (r_pwm_cnt < r_duty);
    end
  end

  assign pwm      = r_pwm;
  assign underrun = r_underrun;

endmodule : pcm_stream_sink
`default_nettype wire

// File: tb/tb_pcm_stream_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pcm_stream_sink                                     |
// | Description : Self-checking bench for pcm_stream_sink. Accepted      |
// |               samples are queued as expected duties; a monitor       |
// |               measures pwm high time per aligned PWM period.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pcm_stream_sink;

  localparam int DEPTH    = 4;
  localparam int RATE_DIV = 512;

  logic        clk            = 1'b0;
  logic        rst_n          = 1'b1;
  logic [7:0]  pcm_in         = 8'h00;
  logic        pcm_in_vld     = 1'b0;
  logic        clear_underrun = 1'b0;
  logic        pcm_in_rdy;
  logic        pwm;
  logic [2:0]  level;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected sequence of distinct PWM duties (high cycles per period).
  int exp_q[$];
  int last_duty = -1;
  int win_n     = 0;
  int win_hi    = 0;

  pcm_stream_sink #(
    .DEPTH    (DEPTH),
    .RATE_DIV (RATE_DIV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pcm_in         (pcm_in),
    .pcm_in_vld     (pcm_in_vld),
    .pcm_in_rdy     (pcm_in_rdy),
    .clear_underrun (clear_underrun),
    .pwm            (pwm),
    .level          (level),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  // Edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pwm after edges 256m+1..256m+256 forms one period.
  always @(negedge clk) begin
    if (!rst_n) begin
      win_n     = 0;
      win_hi    = 0;
      last_duty = -1;
    end else if (cyc >= 1) begin
      win_hi += int'(pwm);
      win_n++;
      if (win_n == 256) begin
        if (win_hi != last_duty) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL duty_unexpected: got %0d, expected no change from %0d (cycle %0d)",
                     win_hi, last_duty, cyc);
          end else begin
            chk("duty", win_hi, exp_q.pop_front());
          end
          last_duty = win_hi;
        end
        win_n  = 0;
        win_hi = 0;
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [7:0] v);
    int n;
    n          = 0;
    pcm_in     = v;
    pcm_in_vld = 1'b1;
    while (!pcm_in_rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!pcm_in_rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got rdy=0, expected rdy=1 within 2000 cycles (cycle %0d)", cyc);
      pcm_in_vld = 1'b0;
    end else begin
      exp_q.push_back(int'(v));
      @(negedge clk);
      pcm_in_vld = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_q.push_back(128);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rdy_first_edge", pcm_in_rdy, 0);
    chk("level_reset", level, 0);
    chk("underrun_reset", underrun, 0);
    chk("pwm_reset", pwm, 0);
    @(negedge clk);
    chk("rdy_second_edge", pcm_in_rdy, 1);

    // First tick with nothing buffered.
    wait_cyc(511);
    chk("underrun_pre_tick", underrun, 0);
    wait_cyc(512);
    chk("underrun_first_tick", underrun, 1);

    // Fill, then a held-valid sample that lands after the next tick.
    wait_cyc(520);
    send(8'h10);
    send(8'h20);
    send(8'h30);
    send(8'h40);
    chk("fill_level", level, 4);
    chk("fill_rdy", pcm_in_rdy, 0);
    send(8'h50);
    chk("held_accept_cycle", cyc, 1025);
    chk("held_level", level, 4);
    chk("held_rdy", pcm_in_rdy, 0);

    // Clear while the FIFO is fed.
    chk("underrun_before_clear", underrun, 1);
    clear_underrun = 1'b1;
    @(negedge clk);
    clear_underrun = 1'b0;
    chk("underrun_cleared", underrun, 0);

    // Drain, then duty extremes.
    wait_cyc(3072);
    chk("drained_level", level, 0);
    wait_cyc(3080);
    send(8'h00);
    send(8'hFF);

    // Clear coincident with an empty tick: set wins.
    wait_cyc(4607);
    chk("underrun_before_empty_tick", underrun, 0);
    clear_underrun = 1'b1;
    @(negedge clk);
    clear_underrun = 1'b0;
    chk("underrun_set_wins", underrun, 1);
    wait_cyc(4700);
    clear_underrun = 1'b1;
    @(negedge clk);
    clear_underrun = 1'b0;
    chk("underrun_recleared", underrun, 0);

    // Push into an empty FIFO on the tick cycle.
    wait_cyc(5119);
    send(8'h55);
    chk("collision_cycle", cyc, 5120);
    chk("collision_level", level, 1);
    chk("collision_underrun", underrun, 1);
    wait_cyc(5632);
    chk("collision_popped_level", level, 0);

    // Reset mid-period with three samples buffered.
    wait_cyc(6149);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    chk("pre_reset_level", level, 3);
    wait_cyc(6160);
    chk("pwm_before_reset", pwm, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    exp_q.push_back(128);
    #1;
    chk("async_reset_pwm", pwm, 0);
    chk("async_reset_level", level, 0);
    chk("async_reset_rdy", pcm_in_rdy, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rerelease_rdy_first_edge", pcm_in_rdy, 0);
    @(negedge clk);
    chk("rerelease_rdy_second_edge", pcm_in_rdy, 1);
    chk("rerelease_level", level, 0);

    wait_cyc(10);
    send(8'h66);
    wait_cyc(1030);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pcm_stream_sink
`default_nettype wire
